// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings and defaults for the fetch stage.
// Imported by fetch_sequencer and pc_counter.
package fetch_pkg;

  localparam int          ADDR_W_D    = 8;
  localparam int          DATA_W_D    = 16;
  localparam logic [15:0] HALT_INSN_D = 16'hE000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    WBUSY,
    WDONE,
    HALT
  } state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with async clear and wrapping increment.
// Advances by one on each retired instruction.
module pc_counter
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions over req/ack and
// hands them to the cpu via load/s, then waits on w.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_D,
  parameter int                DATA_W    = DATA_W_D,
  parameter logic [DATA_W-1:0] HALT_INSN = HALT_INSN_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              halted
);

  state_t            r_state;
  state_t            w_next;
  logic              w_retire;
  logic              w_take;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_load;
  logic              r_s;
  logic              r_halted;
  logic [15:0]       r_retired;
  logic [ADDR_W-1:0] w_pc;

  assign w_take = (r_state == REQ) && mem_ack;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      IDLE:  if (run && cpu_w) w_next = REQ;
      REQ:   if (mem_ack) w_next = LOAD;
      LOAD:  w_next = (r_ir == HALT_INSN) ? HALT : START;
      START: w_next = WBUSY;
      WBUSY: if (!cpu_w) w_next = WDONE;
      WDONE: begin
        if (cpu_w) begin
          w_retire = 1'b1;
          w_next   = run ? REQ : IDLE;
        end
      end
      HALT:  w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are decided one edge early so they are registered
  // yet high during the LOAD / START cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ir      <= '0;
      r_ir_load <= 1'b0;
      r_s       <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_ir_load <= w_take && (mem_rdata != HALT_INSN);
      r_s       <= (w_next == START);
      if (w_take) r_ir <= mem_rdata;
      if (w_next == HALT) r_halted <= 1'b1;
      if (w_retire) r_retired <= sat_inc16(r_retired);
    end
  end

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_retire),
    .o_pc  (w_pc)
  );

  assign mem_req  = (r_state == REQ);
  assign mem_addr = w_pc;
  assign pc       = w_pc;
  assign ir_data  = r_ir;
  assign ir_load  = r_ir_load;
  assign cpu_s    = r_s;
  assign retired  = r_retired;
  assign halted   = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with a scoreboard of
// expected {pc, ir_data} pairs popped on each ir_load.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_data;
  logic        ir_load;
  logic        cpu_s;
  logic        cpu_w;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        halted;

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_data   (ir_data),
    .ir_load   (ir_load),
    .cpu_s     (cpu_s),
    .cpu_w     (cpu_w),
    .pc        (pc),
    .retired   (retired),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [256];
  int          mem_delay = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  int          s_cnt, ld_cnt, req_cnt, req0_cnt;
  logic        prev_s = 1'b0;
  logic        prev_ld = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out (pc=%0h)", nm, pc);
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic clr_stats();
    s_cnt    = 0;
    ld_cnt   = 0;
    req_cnt  = 0;
    req0_cnt = 0;
  endtask

  // memory: ack after mem_delay waiting cycles
  initial begin
    int wc;
    wc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        if (wc >= mem_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wc = 0;
        end else begin
          wc++;
        end
      end else begin
        mem_ack = 1'b0;
        wc = 0;
      end
    end
  end

  // cpu: drop w 1 cycle after s, raise it 4 cycles later
  initial begin
    cpu_w = 1'b1;
    forever begin
      @(negedge clk);
      if (cpu_s) begin
        @(negedge clk);
        cpu_w = 1'b0;
        repeat (4) @(negedge clk);
        cpu_w = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (ir_load) begin
        ld_cnt++;
        check("ir_load_1cyc", {30'd0, ir_load, prev_ld}, 32'd2);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL sb_empty: ir_load pc=%0h ir=%0h", pc, ir_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_addr", {24'd0, pc}, {24'd0, e.a});
          check("sb_data", {16'd0, ir_data}, {16'd0, e.d});
        end
      end
      if (cpu_s) begin
        if (!prev_s) s_cnt++;
        check("cpu_s_1cyc", {30'd0, cpu_s, prev_s}, 32'd2);
      end
      if (mem_req) begin
        req_cnt++;
        if (mem_addr == 8'h00) req0_cnt++;
        check("mem_addr_pc", {24'd0, mem_addr}, {24'd0, pc});
      end
    end
    prev_ld = ir_load;
    prev_s  = cpu_s;
  end

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    mem_delay = 0;
    repeat (2) @(negedge clk);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_ir", {16'd0, ir_data}, 32'd0);
    check("rst_ret", {16'd0, retired}, 32'd0);
    check("rst_bits", {28'd0, mem_req, ir_load, cpu_s, halted}, 32'd0);
    clr_stats();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halted(input string nm, input int lim);
    int c;
    c = 0;
    while (!halted && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (!halted) timeout(nm);
  endtask

  initial begin
    int c;
    reset = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;

    // T1: single instruction, zero-wait, issue latency
    do_reset();
    mem[0] = 16'hD105;
    mem[1] = 16'hE000;
    push(8'h00, 16'hD105);
    run = 1'b1;
    c = 0;
    while (!cpu_s && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("t1_s_latency", c, 32'd3);
    wait_halted("t1_halt", 100);
    check("t1_pc", {24'd0, pc}, 32'd1);
    check("t1_ret", {16'd0, retired}, 32'd1);
    check("t1_loads", ld_cnt, 32'd1);
    check("t1_s", s_cnt, 32'd1);

    // T2: ack delayed 5 cycles
    do_reset();
    mem_delay = 5;
    mem[0] = 16'hA0C8;
    push(8'h00, 16'hA0C8);
    run = 1'b1;
    wait_halted("t2_halt", 200);
    check("t2_req0", req0_cnt, 32'd6);
    check("t2_loads", ld_cnt, 32'd1);
    check("t2_s", s_cnt, 32'd1);

    // T3: three-word program ending in HALT
    do_reset();
    mem[0] = 16'hD105;
    mem[1] = 16'hD207;
    mem[2] = 16'hE000;
    push(8'h00, 16'hD105);
    push(8'h01, 16'hD207);
    run = 1'b1;
    wait_halted("t3_halt", 200);
    check("t3_s", s_cnt, 32'd2);
    check("t3_pc", {24'd0, pc}, 32'd2);
    check("t3_ret", {16'd0, retired}, 32'd2);
    check("t3_halted", {31'd0, halted}, 32'd1);
    req_cnt = 0;
    repeat (20) @(negedge clk);
    check("t3_no_req", req_cnt, 32'd0);

    // T4: pc wrap and retired saturation
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      push(8'(i), 16'h1000 + 16'(i));
    end
    run = 1'b1;
    c = 0;
    while (pc != 8'hFF && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (pc != 8'hFF) timeout("t4_reach_ff");
    run = 1'b0;
    c = 0;
    while (retired != 16'h0100 && c < 100) begin
      @(negedge clk);
      c++;
    end
    req_cnt = 0;
    repeat (5) @(negedge clk);
    check("t4_wrap_pc", {24'd0, pc}, 32'd0);
    check("t4_ret256", {16'd0, retired}, 32'h100);
    check("t4_idle_req", req_cnt, 32'd0);
    check("t4_sb_empty", exp_q.size(), 32'd0);
    force dut.r_retired = 16'hFFFF;
    @(negedge clk);
    release dut.r_retired;
    @(negedge clk);
    check("t4_forced", {16'd0, retired}, 32'hFFFF);
    push(8'h00, 16'h1000);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    c = 0;
    while (pc != 8'h01 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (pc != 8'h01) timeout("t4_sat_instr");
    repeat (3) @(negedge clk);
    check("t4_sat", {16'd0, retired}, 32'hFFFF);
    check("t4_sat_pc", {24'd0, pc}, 32'd1);

    // T5: run dropped during WDONE
    do_reset();
    mem[0] = 16'hD105;
    mem[1] = 16'hD207;
    mem[2] = 16'hE000;
    push(8'h00, 16'hD105);
    run = 1'b1;
    c = 0;
    while (cpu_w && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (cpu_w) timeout("t5_w_low");
    @(negedge clk);
    check("t5_in_wdone", 32'(dut.r_state), 32'(WDONE));
    run = 1'b0;
    req_cnt = 0;
    repeat (8) @(negedge clk);
    check("t5_pc", {24'd0, pc}, 32'd1);
    check("t5_ret", {16'd0, retired}, 32'd1);
    check("t5_no_req", req_cnt, 32'd0);
    check("t5_idle", 32'(dut.r_state), 32'(IDLE));
    push(8'h01, 16'hD207);
    run = 1'b1;
    wait_halted("t5_halt", 200);
    check("t5_pc2", {24'd0, pc}, 32'd2);
    check("t5_ret2", {16'd0, retired}, 32'd2);

    // T6: async reset while in WBUSY
    do_reset();
    push(8'h00, 16'hD105);
    push(8'h01, 16'hD207);
    run = 1'b1;
    c = 0;
    while (!(cpu_s && pc == 8'h01) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!(cpu_s && pc == 8'h01)) timeout("t6_second_s");
    @(posedge clk);
    #1;
    check("t6_wbusy", 32'(dut.r_state), 32'(WBUSY));
    reset = 1'b0;
    #1;
    check("t6_pc", {24'd0, pc}, 32'd0);
    check("t6_bits", {29'd0, mem_req, cpu_s, ir_load}, 32'd0);
    check("t6_ret", {16'd0, retired}, 32'd0);
    check("t6_idle", 32'(dut.r_state), 32'(IDLE));
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    push(8'h00, 16'hD105);
    push(8'h01, 16'hD207);
    run = 1'b1;
    wait_halted("t6_halt", 300);
    check("t6_pc2", {24'd0, pc}, 32'd2);
    check("t6_ret2", {16'd0, retired}, 32'd2);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch stage directly upstream of the cpu block.
- Owns the 8-bit program counter and reads 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction on the cpu's in/load pins, pulses s, then waits on w to learn that execution has finished.
- Advances the PC, stops on a HALT word, and counts retired instructions.

Parameters:
- ADDR_W, 8, PC and memory address width.
- DATA_W, 16, instruction width; must equal the cpu's in width.
- HALT_INSN, 16'hE000, instruction word that stops fetching; it is not issued to the cpu.

Ports:
- clk  input  1  rising-edge clock shared with the cpu.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  level enable; fetching proceeds while 1.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  read address; always equals pc.
- mem_ack  input  1  read data valid; sampled only while mem_req=1.
- mem_rdata  input  DATA_W  instruction word, valid with mem_ack.
- ir_data  output  DATA_W  registered instruction, drives cpu in.
- ir_load  output  1  one-cycle strobe, drives cpu load.
- cpu_s  output  1  one-cycle start pulse, drives cpu s.
- cpu_w  input  1  cpu wait flag (1 = cpu idle, waiting for s).
- pc  output  ADDR_W  current program counter.
- retired  output  16  count of instructions completed by the cpu.
- halted  output  1  1 once HALT_INSN has been fetched.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pc=0; ir_data=0; retired=0; every 1-bit output=0. Reset mid-operation abandons any outstanding memory request. The cpu is reset separately.
- All outputs are registered, except mem_addr (equals pc) and mem_req (decoded from state, 1 only in REQ).
- IDLE: if run=1 and cpu_w=1, go to REQ next cycle. Otherwise stay.
- REQ: mem_req=1, mem_addr=pc.
  - On an edge with mem_ack=1: capture ir_data<=mem_rdata, go to LOAD.
  - mem_ack may be combinational, so REQ can last a single cycle.
  - mem_ack in any other state is ignored.
- LOAD:
  - If ir_data==HALT_INSN: go to HALT; ir_load is not asserted.
  - Otherwise: ir_load=1 for exactly this cycle, ir_data is held, go to START.
- START: cpu_s=1 for exactly one cycle, go to WBUSY.
- WBUSY: wait for cpu_w=0, meaning the cpu has left its wait state, then go to WDONE. cpu_s stays 0.
- WDONE: wait for cpu_w=1. On that edge:
  - pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
  - retired<=retired+1, saturating at 16'hFFFF.
  - Go to REQ if run=1, else IDLE.
- HALT: halted=1; pc keeps the HALT address; no requests are issued. Leave HALT only via reset.
- run falling while in REQ..WDONE: the current instruction completes, then the block parks in IDLE with pc already advanced. A new run=1 resumes at that pc.
- Best-case issue latency: run sampled 1 in IDLE → REQ (1 cycle, zero-wait ack) → LOAD → START. cpu_s is high 3 cycles after run is sampled.
- Throughput: one instruction per (3 + memory wait + cpu execution) cycles.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding: IDLE, REQ, LOAD, START, WBUSY, WDONE, HALT;
  - HALT_INSN default;
  - ADDR_W and DATA_W defaults.
- One sub-module, pc_counter (ADDR_W-wide register with clear and increment, wrap-around), instantiated once.
- The state machine, ir_data register and retired counter stay in fetch_sequencer.

Test Plan:
- Reset released, run=1, memory[0]=16'hD105, zero-wait ack, cpu model drops w 1 cycle after s and raises it 4 cycles later → ir_data=16'hD105 with ir_load pulsed once; cpu_s high 3 cycles after run; afterwards pc=1, retired=1.
- Memory ack delayed 5 cycles, mem_rdata=16'hA0C8 → mem_req held 6 cycles with mem_addr=0; ir_load and cpu_s each single-cycle; ir_data=16'hA0C8.
- Program {D105, D207, E000} at addresses 0..2 → 2 cpu_s pulses; halted=1 with pc=2 and retired=2; mem_req stays 0 for 20 further cycles.
- pc preloaded to 8'hFF via run sequence, instruction completes → pc wraps to 8'h00; retired counter saturation checked by forcing 16'hFFFF → stays 16'hFFFF.
- run dropped during WDONE → block returns to IDLE after w=1 with pc advanced by 1; run=1 again → fetch resumes at the new pc.
- reset driven 0 while in WBUSY → asynchronously: pc=0, mem_req=0, cpu_s=0, ir_load=0, state=IDLE; after release with run=1, fetch restarts at address 0.
